// File: rtl/sap1_pkg.sv
`default_nettype none
// sap1_pkg: widths and selector encodings shared by the SAP-1 address path.
// Revision: 1.0
package sap1_pkg;
    localparam int   SAP1_ADDR_W = 4;
    localparam logic SEL_PROG    = 1'b0;
    localparam logic SEL_RUN     = 1'b1;
endpackage
`default_nettype wire

// File: rtl/sap1_reg4_173.sv
`default_nettype none
// sap1_reg4_173: 74LS173-style register, async active-low clear, gated load, tri-state outputs.
// Revision: 1.0
module sap1_reg4_173
    import sap1_pkg::*;
#(
    parameter int WIDTH = SAP1_ADDR_W
) (
    input  logic             CLK,
    input  logic             CLR_bar,
    input  logic             G1_bar,
    input  logic             G2_bar,
    input  logic             M,
    input  logic             N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] q_reg;
    logic             load;

    assign load = ~G1_bar & ~G2_bar;

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= D;
        end
    end

    // Either output-enable pin high floats the outputs, as on the real part.
    assign Q = (M | N) ? {WIDTH{1'bz}} : q_reg;
endmodule
`default_nettype wire

// File: rtl/sap1_input_mar.sv
`default_nettype none
// sap1_input_mar: SAP-1 memory address register feeding a RUN/PROG address selector.
// Revision: 1.0
module sap1_input_mar
    import sap1_pkg::*;
#(
    parameter int WIDTH = SAP1_ADDR_W
) (
    input  logic             CLK,
    input  logic             CLR_bar,
    input  logic             L_M_bar,
    input  logic [WIDTH-1:0] bus_input,
    input  logic [WIDTH-1:0] program_data,
    input  logic             run_or_prog,
    output logic [WIDTH-1:0] address
);
    logic [WIDTH-1:0] mar_q;

    // Both data enables share the controller's Lm_bar; outputs permanently enabled.
    sap1_reg4_173 #(
        .WIDTH (WIDTH)
    ) mar (
        .CLK     (CLK),
        .CLR_bar (CLR_bar),
        .G1_bar  (L_M_bar),
        .G2_bar  (L_M_bar),
        .M       (1'b0),
        .N       (1'b0),
        .D       (bus_input),
        .Q       (mar_q)
    );

    assign address = (run_or_prog == SEL_RUN) ? mar_q : program_data;
endmodule
`default_nettype wire

// File: tb/tb_sap1_input_mar.sv
`default_nettype none
// tb_sap1_input_mar: directed and randomized checks against a behavioural address model.
// Revision: 1.0
module tb_sap1_input_mar;
    logic       CLK = 1'b0;
    logic       CLR_bar;
    logic       L_M_bar;
    logic [3:0] bus_input;
    logic [3:0] program_data;
    logic       run_or_prog;
    logic [3:0] address;

    int total = 0;
    int bad   = 0;
    int mar_m = 0;

    sap1_input_mar dut (
        .CLK          (CLK),
        .CLR_bar      (CLR_bar),
        .L_M_bar      (L_M_bar),
        .bus_input    (bus_input),
        .program_data (program_data),
        .run_or_prog  (run_or_prog),
        .address      (address)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_addr();
        return run_or_prog ? 4'(mar_m) : program_data;
    endfunction

    // One rising edge; the model captures the inputs present at that edge.
    task automatic step();
        @(posedge CLK);
        if (!CLR_bar)      mar_m = 0;
        else if (!L_M_bar) mar_m = int'(bus_input);
        #1;
    endtask

    initial begin
        CLR_bar = 1'b0; L_M_bar = 1'b1; bus_input = 4'h0;
        program_data = 4'h7; run_or_prog = 1'b1;
        #2;
        check("reset_run", address, 4'h0);
        run_or_prog = 1'b0; #1;
        check("reset_prog", address, 4'h7);
        step(); step();
        CLR_bar = 1'b1; run_or_prog = 1'b1;

        // 1
        L_M_bar = 1'b0; bus_input = 4'h3; program_data = 4'h7;
        step();
        check("load_3", address, 4'h3);
        // 2
        run_or_prog = 1'b0; #1;
        check("prog_imm", address, 4'h7);
        L_M_bar = 1'b1; bus_input = 4'hC;
        step();
        check("prog_hold", address, 4'h7);
        // 3
        run_or_prog = 1'b1; #1;
        check("run_held", address, 4'h3);
        // 4
        L_M_bar = 1'b0;
        step();
        check("load_C", address, 4'hC);
        for (int v = 0; v < 16; v++) begin
            bus_input = 4'(v);
            step();
            check("sweep_bus", address, 4'(v));
        end
        bus_input = 4'hC;
        step();
        // 5
        #2; CLR_bar = 1'b0; mar_m = 0; #1;
        check("async_clr", address, 4'h0);
        bus_input = 4'h9;
        step();
        check("clr_over_load", address, 4'h0);
        CLR_bar = 1'b1;
        // 6
        bus_input = 4'h5; run_or_prog = 1'b0;
        for (int v = 0; v < 16; v++) begin
            program_data = 4'(v); #1;
            check("prog_sweep", address, 4'(v));
            step();
            check("prog_sweep_edge", address, 4'(v));
        end
        run_or_prog = 1'b1; #1;
        check("run_return", address, 4'h5);

        // Randomized: inputs change mid-cycle, combinational and post-edge checks.
        for (int i = 0; i < 300; i++) begin
            L_M_bar      = 1'($urandom_range(0, 1));
            bus_input    = 4'($urandom);
            program_data = 4'($urandom);
            run_or_prog  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                CLR_bar = 1'b0; mar_m = 0;
            end else begin
                CLR_bar = 1'b1;
            end
            #1;
            check("rnd_comb", address, model_addr());
            step();
            check("rnd_edge", address, model_addr());
            if ($urandom_range(0, 3) == 0) begin
                run_or_prog = ~run_or_prog; #1;
                check("rnd_mode", address, model_addr());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
